adf_frame_ctrl: RTL and testbench

Frame-level sequencer between the SPI slave deserializer and the 32-order adaptive filter core. It recognises the 3-word host frame: sync word, then input sample x (AD_1), then desired sample d (AD_2). It then launches one filter update, waits for completion and hands the filter output to the SPI transmit shifter for return on miso. It also handles resync, inter-word timeouts, overrun and a stuck filter.

---
 rtl/adf_pkg.sv | 25 ++
 rtl/adf_timeout_cnt.sv | 28 ++
 rtl/adf_frame_ctrl.sv | 146 ++++++++++++++
 tb/tb_adf_frame_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adf_pkg.sv
// Shared constants and types for the adaptive filter frame path.
// Timeout defaults are also used by the SPI front end.
package adf_pkg;

  localparam int W           = 14;
  localparam int GAP_TIMEOUT = 2048;
  localparam int RUN_TIMEOUT = 4096;
  localparam int CW          = 12;

  localparam logic [W-1:0] SYNC_WORD = 14'h0FFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_X = 3'd1,
    WAIT_D = 3'd2,
    RUN    = 3'd3,
    OUT    = 3'd4
  } state_e;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] d;
  } flt_req_t;

endpackage

// File: rtl/adf_timeout_cnt.sv
// Saturating timeout counter with a run-time limit.
// expired is raised while enabled and the count sits at the limit.
module adf_timeout_cnt #(
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] limit,
  output logic          expired
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && (cnt == limit);

endmodule

// File: rtl/adf_frame_ctrl.sv
// Host frame sequencer: sync, x, d -> one filter update -> tx word.
// Handles resync, gap/run timeouts and overrun.
module adf_frame_ctrl
  import adf_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  input  logic         rx_valid,
  input  logic [W-1:0] rx_word,
  output logic         flt_start,
  output logic [W-1:0] flt_x,
  output logic [W-1:0] flt_d,
  input  logic         flt_done,
  input  logic [W-1:0] flt_y,
  output logic [W-1:0] tx_word,
  output logic         tx_load,
  output logic         busy,
  output logic [15:0]  frame_cnt,
  output logic         err_ovr,
  output logic         err_tmo,
  input  logic         err_clr
);

  localparam logic [CW-1:0] GAP_LIM =
    CW'(GAP_TIMEOUT - 1);
  localparam logic [CW-1:0] RUN_LIM =
    CW'(RUN_TIMEOUT - 1);

  state_e   state_q, state_d;
  flt_req_t req_q;

  logic          is_sync;
  logic          in_gap;
  logic          tmr_en;
  logic          tmr_clr;
  logic          tmr_exp;
  logic [CW-1:0] tmr_lim;

  logic cap_x, cap_d, start_d;
  logic ovr_set, tmo_set;

  assign is_sync = (rx_word == SYNC_WORD);
  assign in_gap  = (state_q == WAIT_X) ||
                   (state_q == WAIT_D);
  assign tmr_en  = in_gap || (state_q == RUN);
  assign tmr_lim = (state_q == RUN) ? RUN_LIM
                                    : GAP_LIM;

  // Any state change restarts the shared timer.
  assign tmr_clr = (state_d != state_q) ||
                   (in_gap && rx_valid);

  adf_timeout_cnt #(.CW(CW)) u_tmr (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .limit   (tmr_lim),
    .expired (tmr_exp)
  );

  always_comb begin
    state_d = state_q;
    cap_x   = 1'b0;
    cap_d   = 1'b0;
    start_d = 1'b0;
    ovr_set = 1'b0;
    tmo_set = 1'b0;
    unique case (state_q)
      IDLE, OUT: begin
        if (rx_valid && is_sync) begin
          state_d = WAIT_X;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_X: begin
        if (rx_valid) begin
          if (!is_sync) begin
            cap_x   = 1'b1;
            state_d = WAIT_D;
          end
        end else if (tmr_exp) begin
          tmo_set = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_D: begin
        if (rx_valid) begin
          if (is_sync) begin
            state_d = WAIT_X;
          end else begin
            cap_d   = 1'b1;
            start_d = 1'b1;
            state_d = RUN;
          end
        end else if (tmr_exp) begin
          tmo_set = 1'b1;
          state_d = IDLE;
        end
      end
      RUN: begin
        ovr_set = rx_valid;
        if (flt_done) begin
          state_d = OUT;
        end else if (tmr_exp) begin
          tmo_set = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      req_q     <= '0;
      flt_start <= 1'b0;
      tx_word   <= '0;
      tx_load   <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
      err_ovr   <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      state_q   <= state_d;
      flt_start <= start_d;
      tx_load   <= (state_d == OUT);
      busy      <= (state_d != IDLE);
      if (cap_x) req_q.x <= rx_word;
      if (cap_d) req_q.d <= rx_word;
      if (state_d == OUT) begin
        tx_word   <= flt_y;
        frame_cnt <= frame_cnt + 16'd1;
      end
      // A same-cycle set beats err_clr.
      err_ovr <= ovr_set | (err_ovr & ~err_clr);
      err_tmo <= tmo_set | (err_tmo & ~err_clr);
    end
  end

  assign flt_x = req_q.x;
  assign flt_d = req_q.d;

endmodule

// File: tb/tb_adf_frame_ctrl.sv
// Directed bench for adf_frame_ctrl: vector table plus
// hand sequences for timeouts, overrun, reset and a sweep.
module tb_adf_frame_ctrl;
  import adf_pkg::*;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         rx_valid = 1'b0;
  logic [W-1:0] rx_word = '0;
  logic         flt_start;
  logic [W-1:0] flt_x, flt_d;
  logic         flt_done = 1'b0;
  logic [W-1:0] flt_y = '0;
  logic [W-1:0] tx_word;
  logic         tx_load;
  logic         busy;
  logic [15:0]  frame_cnt;
  logic         err_ovr, err_tmo;
  logic         err_clr = 1'b0;

  always #5 clk = ~clk;

  adf_frame_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx_valid  (rx_valid),
    .rx_word   (rx_word),
    .flt_start (flt_start),
    .flt_x     (flt_x),
    .flt_d     (flt_d),
    .flt_done  (flt_done),
    .flt_y     (flt_y),
    .tx_word   (tx_word),
    .tx_load   (tx_load),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .err_ovr   (err_ovr),
    .err_tmo   (err_tmo),
    .err_clr   (err_clr)
  );

  int n_run = 0;
  int n_fail = 0;
  int n_start = 0;
  int n_load = 0;

  always @(posedge clk) begin
    if (flt_start) n_start++;
    if (tx_load) n_load++;
  end

  typedef struct {
    logic         rv;
    logic [W-1:0] w;
    logic         dn;
    logic [W-1:0] y;
    logic         st;
    logic         ld;
    logic         bz;
    logic [W-1:0] x;
    logic [W-1:0] d;
    logic [W-1:0] tx;
    logic [15:0]  fc;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(
    input logic rv, input logic [W-1:0] w,
    input logic dn, input logic [W-1:0] y,
    input logic st, input logic ld,
    input logic bz, input logic [W-1:0] x,
    input logic [W-1:0] d,
    input logic [W-1:0] tx,
    input logic [15:0] fc);
    vec_t v;
    v.rv = rv; v.w = w; v.dn = dn; v.y = y;
    v.st = st; v.ld = ld; v.bz = bz;
    v.x = x; v.d = d; v.tx = tx; v.fc = fc;
    return v;
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [W-1:0] w);
    rx_valid = 1'b1;
    rx_word  = w;
    tick();
    rx_valid = 1'b0;
    rx_word  = '0;
  endtask

  task automatic done(input logic [W-1:0] y);
    flt_done = 1'b1;
    flt_y    = y;
    tick();
    flt_done = 1'b0;
    flt_y    = '0;
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    int s0, l0, lat;
    logic [W-1:0] x, y;

    //     rv w        dn y        st ld bz x        d        tx       fc
    tbl[0]  = mk(1, 14'h0123, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 14'h0FFF, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[2]  = mk(1, 14'h054B, 0, 0, 0, 0, 1,
                 14'h054B, 0, 0, 0);
    tbl[3]  = mk(1, 14'h054C, 0, 0, 1, 0, 1,
                 14'h054B, 14'h054C, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 1,
                 14'h054B, 14'h054C, 0, 0);
    tbl[5]  = mk(0, 0, 1, 14'h1234, 0, 1, 1,
                 14'h054B, 14'h054C, 14'h1234, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0,
                 14'h054B, 14'h054C, 14'h1234, 1);
    tbl[7]  = mk(1, 14'h0FFF, 0, 0, 0, 0, 1,
                 14'h054B, 14'h054C, 14'h1234, 1);
    tbl[8]  = mk(1, 14'h0100, 0, 0, 0, 0, 1,
                 14'h0100, 14'h054C, 14'h1234, 1);
    tbl[9]  = mk(1, 14'h0FFF, 0, 0, 0, 0, 1,
                 14'h0100, 14'h054C, 14'h1234, 1);
    tbl[10] = mk(1, 14'h0200, 0, 0, 0, 0, 1,
                 14'h0200, 14'h054C, 14'h1234, 1);
    tbl[11] = mk(1, 14'h0201, 0, 0, 1, 0, 1,
                 14'h0200, 14'h0201, 14'h1234, 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 1,
                 14'h0200, 14'h0201, 14'h1234, 1);
    tbl[13] = mk(0, 0, 1, 14'h0ABC, 0, 1, 1,
                 14'h0200, 14'h0201, 14'h0ABC, 2);
    tbl[14] = mk(1, 14'h0FFF, 0, 0, 0, 0, 1,
                 14'h0200, 14'h0201, 14'h0ABC, 2);
    tbl[15] = mk(1, 14'h0777, 0, 0, 0, 0, 1,
                 14'h0777, 14'h0201, 14'h0ABC, 2);
    tbl[16] = mk(1, 14'h0FFF, 0, 0, 0, 0, 1,
                 14'h0777, 14'h0201, 14'h0ABC, 2);
    tbl[17] = mk(1, 14'h0778, 0, 0, 0, 0, 1,
                 14'h0778, 14'h0201, 14'h0ABC, 2);
    tbl[18] = mk(1, 14'h0779, 0, 0, 1, 0, 1,
                 14'h0778, 14'h0779, 14'h0ABC, 2);
    tbl[19] = mk(0, 0, 1, 14'h0001, 0, 1, 1,
                 14'h0778, 14'h0779, 14'h0001, 3);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0,
                 14'h0778, 14'h0779, 14'h0001, 3);
    tbl[21] = mk(0, 0, 1, 14'h3FFF, 0, 0, 0,
                 14'h0778, 14'h0779, 14'h0001, 3);

    // Reset state
    idle(2);
    check("rst.busy", busy, 0);
    check("rst.start", flt_start, 0);
    check("rst.load", tx_load, 0);
    check("rst.x", flt_x, 0);
    check("rst.d", flt_d, 0);
    check("rst.tx", tx_word, 0);
    check("rst.fc", frame_cnt, 0);
    check("rst.ovr", err_ovr, 0);
    check("rst.tmo", err_tmo, 0);
    rstn = 1'b1;
    idle(2);

    // Vector table: basic, resync, sync in OUT
    for (int i = 0; i < 22; i++) begin
      rx_valid = tbl[i].rv;
      rx_word  = tbl[i].w;
      flt_done = tbl[i].dn;
      flt_y    = tbl[i].y;
      tick();
      rx_valid = 1'b0;
      rx_word  = '0;
      flt_done = 1'b0;
      flt_y    = '0;
      check($sformatf("v%0d.start", i),
            flt_start, tbl[i].st);
      check($sformatf("v%0d.load", i),
            tx_load, tbl[i].ld);
      check($sformatf("v%0d.busy", i),
            busy, tbl[i].bz);
      check($sformatf("v%0d.x", i), flt_x, tbl[i].x);
      check($sformatf("v%0d.d", i), flt_d, tbl[i].d);
      check($sformatf("v%0d.tx", i),
            tx_word, tbl[i].tx);
      check($sformatf("v%0d.fc", i),
            frame_cnt, tbl[i].fc);
      check($sformatf("v%0d.ovr", i), err_ovr, 0);
      check($sformatf("v%0d.tmo", i), err_tmo, 0);
    end

    // Gap timeout in WAIT_D: expires on the 2048th idle cycle
    s0 = n_start;
    send(14'h0FFF);
    send(14'h0300);
    idle(GAP_TIMEOUT - 1);
    check("gap.busy_pre", busy, 1);
    check("gap.tmo_pre", err_tmo, 0);
    idle(1);
    check("gap.busy", busy, 0);
    check("gap.tmo", err_tmo, 1);
    check("gap.nostart", n_start - s0, 0);
    send(14'h0FFF);
    send(14'h0001);
    send(14'h0002);
    check("gap.next_start", flt_start, 1);
    check("gap.next_x", flt_x, 14'h0001);
    check("gap.next_d", flt_d, 14'h0002);
    idle(3);
    done(14'h0042);
    check("gap.next_load", tx_load, 1);
    check("gap.next_tx", tx_word, 14'h0042);
    check("gap.next_fc", frame_cnt, 4);
    check("gap.tmo_sticky", err_tmo, 1);
    clr_err();
    check("gap.tmo_clr", err_tmo, 0);

    // Overrun and run timeout
    l0 = n_load;
    send(14'h0FFF);
    send(14'h0A00);
    send(14'h0A01);
    check("run.start", flt_start, 1);
    send(14'h0555);
    check("run.ovr", err_ovr, 1);
    check("run.ovr_busy", busy, 1);
    rx_valid = 1'b1;
    rx_word  = 14'h0556;
    err_clr  = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_word  = '0;
    err_clr  = 1'b0;
    check("run.set_wins", err_ovr, 1);
    idle(RUN_TIMEOUT - 3);
    check("run.busy_pre", busy, 1);
    check("run.tmo_pre", err_tmo, 0);
    idle(1);
    check("run.busy", busy, 0);
    check("run.tmo", err_tmo, 1);
    check("run.noload", n_load - l0, 0);
    clr_err();
    check("run.ovr_clr", err_ovr, 0);
    check("run.tmo_clr", err_tmo, 0);

    // Reset mid-RUN
    send(14'h0FFF);
    send(14'h0B00);
    send(14'h0B01);
    idle(5);
    l0 = n_load;
    #2 rstn = 1'b0;
    #1;
    check("mrst.busy", busy, 0);
    check("mrst.x", flt_x, 0);
    check("mrst.d", flt_d, 0);
    check("mrst.tx", tx_word, 0);
    check("mrst.fc", frame_cnt, 0);
    tick();
    rstn = 1'b1;
    done(14'h1111);
    idle(1);
    check("mrst.noload", n_load - l0, 0);
    check("mrst.busy_after", busy, 0);

    // Sweep of host-pattern frames
    l0 = n_load;
    for (int k = 0; k < 47; k++) begin
      x = 14'h054B + 14'(15 * k);
      y = x ^ 14'h2AAA;
      lat = (k % 8 == 0) ? 2000 : 200;
      send(14'h0FFF);
      send(x);
      send(x + 14'd1);
      check($sformatf("sw%0d.start", k), flt_start, 1);
      check($sformatf("sw%0d.x", k), flt_x, x);
      check($sformatf("sw%0d.d", k), flt_d, x + 14'd1);
      idle(lat - 1);
      done(y);
      check($sformatf("sw%0d.load", k), tx_load, 1);
      check($sformatf("sw%0d.tx", k), tx_word, y);
      check($sformatf("sw%0d.fc", k), frame_cnt, k + 1);
      idle(1);
    end
    check("sw.loads", n_load - l0, 47);
    check("sw.fc", frame_cnt, 47);
    check("sw.ovr", err_ovr, 0);
    check("sw.tmo", err_tmo, 0);
    check("sw.busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
